// File: rtl/dsa_pkg.sv
// Shared types for the DSA signing sequencer: FSM states,
// multiplier operand/modulus selects and the latency formula.
package dsa_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EXP,
        ST_RED_R,
        ST_INV,
        ST_RED_H,
        ST_MUL_XR,
        ST_ADD,
        ST_MUL_S,
        ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        SRC_ONE,
        SRC_Y,
        SRC_KINV,
        SRC_G,
        SRC_K,
        SRC_X,
        SRC_R,
        SRC_T,
        SRC_HM
    } src_e;

    typedef enum logic {
        MOD_P,
        MOD_Q
    } mod_e;

    function automatic int lat(input int w, input int n);
        return (4 * n + 4) * (w + 1) + 2;
    endfunction

endpackage

// File: rtl/mod_mul_ser.sv
// Bit-serial MSB-first interleaved modular multiplier:
// p = a*b mod m in W cycles, requires a < m.
module mod_mul_ser #(
    parameter int W = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0] ar;
    logic [W-1:0] br;
    logic [W-1:0] mr;
    logic [CW-1:0] cnt;

    logic         launch;
    logic [W-1:0] cur_acc;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_m;
    logic         cur_bit;
    logic [W-1:0] nxt;

    function automatic logic [W-1:0] step(
        input logic [W-1:0] acc,
        input logic         bit_i,
        input logic [W-1:0] av,
        input logic [W-1:0] mv
    );
        logic [W:0] d;
        logic [W:0] u;
        d = {acc, 1'b0};
        if (d >= {1'b0, mv}) d = d - {1'b0, mv};
        u = d + (bit_i ? {1'b0, av} : '0);
        if (u >= {1'b0, mv}) u = u - {1'b0, mv};
        return u[W-1:0];
    endfunction

    // The launch edge already performs the first iteration.
    assign launch = start & ~busy;

    always_comb begin
        cur_acc = launch ? '0 : p;
        cur_a   = launch ? a : ar;
        cur_m   = launch ? m : mr;
        cur_bit = launch ? b[W-1] : br[W-1];
        nxt     = step(cur_acc, cur_bit, cur_a, cur_m);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ar   <= '0;
            br   <= '0;
            mr   <= '0;
            cnt  <= '0;
            p    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                ar   <= a;
                mr   <= m;
                br   <= b << 1;
                p    <= nxt;
                cnt  <= CW'(W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                p   <= nxt;
                br  <= br << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dsa_sign_seq.sv
// Constant-time DSA signer: r = (g^k mod p) mod q,
// s = k^-1 (H(m) + x r) mod q on one shared serial multiplier.
module dsa_sign_seq
    import dsa_pkg::*;
#(
    parameter int W = 1024,
    parameter int N = 160
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] p,
    input  logic [N-1:0] q,
    input  logic [W-1:0] g,
    input  logic [N-1:0] x,
    input  logic [N-1:0] k,
    input  logic [W-1:0] hm,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] r,
    output logic [N-1:0] s
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e        state;
    logic          phase;
    logic [CW-1:0] bcnt;
    logic          mstart;

    logic [W-1:0] pr;
    logic [N-1:0] qr;
    logic [W-1:0] gr;
    logic [N-1:0] xr;
    logic [N-1:0] kr;
    logic [W-1:0] hr;
    logic [N-1:0] qm2;

    logic [W-1:0] y;
    logic [N-1:0] kinv;
    logic [N-1:0] h;
    logic [N-1:0] t;
    logic [N-1:0] ri;

    src_e         asel;
    src_e         bsel;
    mod_e         msel;
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic [W-1:0] mm;
    logic [W-1:0] mp;
    logic         mbusy;
    logic         mdone;
    logic         mul_ready;
    logic         ebit;

    function automatic logic [W-1:0] pick(
        input src_e         sel,
        input logic [W-1:0] yv,
        input logic [W-1:0] gv,
        input logic [W-1:0] hv,
        input logic [N-1:0] kiv,
        input logic [N-1:0] kv,
        input logic [N-1:0] xv,
        input logic [N-1:0] rv,
        input logic [N-1:0] tv
    );
        logic [W-1:0] o;
        unique case (sel)
            SRC_Y:    o = yv;
            SRC_KINV: o = W'(kiv);
            SRC_G:    o = gv;
            SRC_K:    o = W'(kv);
            SRC_X:    o = W'(xv);
            SRC_R:    o = W'(rv);
            SRC_T:    o = W'(tv);
            SRC_HM:   o = hv;
            default:  o = W'(1);
        endcase
        return o;
    endfunction

    function automatic logic [N-1:0] add_mod(
        input logic [N-1:0] av,
        input logic [N-1:0] bv,
        input logic [N-1:0] mv
    );
        logic [N:0] sum;
        sum = {1'b0, av} + {1'b0, bv};
        if (sum >= {1'b0, mv}) sum = sum - {1'b0, mv};
        return sum[N-1:0];
    endfunction

    // Phase 0 squares the running value, phase 1 multiplies by the base.
    always_comb begin
        asel = SRC_ONE;
        bsel = SRC_Y;
        msel = MOD_Q;
        unique case (state)
            ST_EXP: begin
                msel = MOD_P;
                asel = phase ? SRC_G : SRC_Y;
                bsel = SRC_Y;
            end
            ST_INV: begin
                asel = phase ? SRC_K : SRC_KINV;
                bsel = SRC_KINV;
            end
            ST_RED_H:  bsel = SRC_HM;
            ST_MUL_XR: begin
                asel = SRC_X;
                bsel = SRC_R;
            end
            ST_MUL_S: begin
                asel = SRC_KINV;
                bsel = SRC_T;
            end
            default: ;
        endcase
    end

    assign ma = pick(asel, y, gr, hr, kinv, kr, xr, ri, t);
    assign mb = pick(bsel, y, gr, hr, kinv, kr, xr, ri, t);
    assign mm = (msel == MOD_P) ? pr : W'(qr);

    assign mul_ready = mdone & ~mbusy;
    assign ebit      = (state == ST_INV) ? qm2[bcnt] : kr[bcnt];

    mod_mul_ser #(.W(W)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mstart),
        .a     (ma),
        .b     (mb),
        .m     (mm),
        .busy  (mbusy),
        .done  (mdone),
        .p     (mp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            phase  <= 1'b0;
            bcnt   <= '0;
            mstart <= 1'b0;
            pr     <= '0;
            qr     <= '0;
            gr     <= '0;
            xr     <= '0;
            kr     <= '0;
            hr     <= '0;
            qm2    <= '0;
            y      <= '0;
            kinv   <= '0;
            h      <= '0;
            t      <= '0;
            ri     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            r      <= '0;
            s      <= '0;
        end else begin
            mstart <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        pr    <= p;
                        qr    <= q;
                        gr    <= g;
                        xr    <= x;
                        kr    <= k;
                        hr    <= hm;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        r     <= '0;
                        s     <= '0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    y     <= W'(1);
                    kinv  <= N'(1);
                    bcnt  <= CW'(N - 1);
                    phase <= 1'b0;
                    qm2   <= qr - N'(2);
                    if (kr == '0 || kr >= qr) begin
                        state <= ST_DONE;
                    end else begin
                        mstart <= 1'b1;
                        state  <= ST_EXP;
                    end
                end
                // Both products are always computed; the bit only
                // decides whether the multiply result is kept.
                ST_EXP, ST_INV: begin
                    if (mul_ready) begin
                        mstart <= 1'b1;
                        phase  <= ~phase;
                        if (!phase || ebit) begin
                            if (state == ST_EXP) y <= mp;
                            else kinv <= mp[N-1:0];
                        end
                        if (phase) begin
                            if (bcnt == '0) begin
                                bcnt  <= CW'(N - 1);
                                state <= (state == ST_EXP) ? ST_RED_R
                                                           : ST_RED_H;
                            end else begin
                                bcnt <= bcnt - CW'(1);
                            end
                        end
                    end
                end
                ST_RED_R: begin
                    if (mul_ready) begin
                        ri     <= mp[N-1:0];
                        mstart <= 1'b1;
                        state  <= ST_INV;
                    end
                end
                ST_RED_H: begin
                    if (mul_ready) begin
                        h      <= mp[N-1:0];
                        mstart <= 1'b1;
                        state  <= ST_MUL_XR;
                    end
                end
                ST_MUL_XR: begin
                    if (mul_ready) begin
                        t     <= mp[N-1:0];
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    t      <= add_mod(t, h, qr);
                    mstart <= 1'b1;
                    state  <= ST_MUL_S;
                end
                ST_MUL_S: begin
                    if (mul_ready) begin
                        r     <= ri;
                        s     <= mp[N-1:0];
                        err   <= (ri == '0) || (mp[N-1:0] == '0);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                // Rejected k arrives here with done low and raises it a
                // cycle later; a finished signature arrives with done high.
                ST_DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
